// File: rtl/i2s_stereo_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stereo_receiver_if
// Brief    : Serial pins, error control and sample outputs of the I2S receiver.
// Revision : 1.0  initial release
// ============================================================================
interface i2s_stereo_receiver_if #(
    parameter int DATA_W = 16
);
    logic              word_select;
    logic              sound_data;
    logic              clear_error;
    logic [DATA_W-1:0] left_sample;
    logic [DATA_W-1:0] right_sample;
    logic              sample_valid;
    logic              locked;
    logic              sync_error;

    modport master (
        output word_select, sound_data, clear_error,
        input  left_sample, right_sample, sample_valid, locked, sync_error
    );

    modport slave (
        input  word_select, sound_data, clear_error,
        output left_sample, right_sample, sample_valid, locked, sync_error
    );
endinterface
`default_nettype wire

// File: rtl/i2s_stereo_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stereo_receiver
// Brief    : Stereo I2S deserialiser with slot-length checking and self-resync.
// Revision : 1.0  initial release
// ============================================================================
module i2s_stereo_receiver #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 32,
    parameter bit LEFT_WS = 1'b0
) (
    input  wire                  serial_clk,
    input  wire                  reset,
    i2s_stereo_receiver_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(SLOT_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(SLOT_W - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT     = c_CNT_W'(SLOT_W);
    localparam logic [c_CNT_W-1:0] c_DATA_CNT = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_SEARCH  = 1'b0;
    localparam logic [0:0] c_ST_RECEIVE = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               r_prev_ws;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_left_hold;
    logic               r_left_ok;
    logic [DATA_W-1:0]  r_left_sample;
    logic [DATA_W-1:0]  r_right_sample;
    logic               r_sample_valid;
    logic               r_sync_error;

    logic [DATA_W-1:0]  w_shift_in;
    logic [DATA_W-1:0]  w_word;
    logic               w_edge;
    logic               w_left_slot;
    logic               w_store_left;
    logic               w_commit;
    logic               w_err_set;
    logic               w_left_ok_nxt;

    if (DATA_W > 1) begin : g_shift_wide
        assign w_shift_in = {r_shift[DATA_W-2:0], bus.sound_data};
    end else begin : g_shift_single
        assign w_shift_in = bus.sound_data;
    end

    assign w_edge      = (bus.word_select != r_prev_ws);
    assign w_left_slot = (r_prev_ws == LEFT_WS);
    // When the slot is exactly DATA_W long, its LSB arrives on the edge cycle itself.
    assign w_word      = (r_bit_cnt < c_DATA_CNT) ? w_shift_in : r_shift;

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_store_left  = 1'b0;
        w_commit      = 1'b0;
        w_err_set     = 1'b0;
        w_left_ok_nxt = r_left_ok;
        case (r_state)
            c_ST_SEARCH: begin
                if (w_edge) begin
                    w_state_nxt = c_ST_RECEIVE;
                end
            end
            c_ST_RECEIVE: begin
                if (w_edge) begin
                    if (r_bit_cnt == c_LAST) begin
                        if (w_left_slot) begin
                            w_store_left  = 1'b1;
                            w_left_ok_nxt = 1'b1;
                        end else if (r_left_ok) begin
                            w_commit      = 1'b1;
                            w_left_ok_nxt = 1'b0;
                        end
                    end else begin
                        // Wrong slot length: flag it and restart counting from this edge.
                        w_err_set     = 1'b1;
                        w_left_ok_nxt = 1'b0;
                    end
                end else if (r_bit_cnt == c_LAST) begin
                    w_err_set     = 1'b1;
                    w_left_ok_nxt = 1'b0;
                    w_state_nxt   = c_ST_SEARCH;
                end
            end
            default: begin
                w_state_nxt = c_ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            r_prev_ws      <= 1'b0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_left_hold    <= '0;
            r_left_ok      <= 1'b0;
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
            r_sync_error   <= 1'b0;
        end else begin
            r_prev_ws <= bus.word_select;
            if (w_edge) begin
                r_bit_cnt <= '0;
            end else if (r_bit_cnt != c_SLOT) begin
                r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
            end
            if (r_bit_cnt < c_DATA_CNT) begin
                r_shift <= w_shift_in;
            end
            if (w_store_left) begin
                r_left_hold <= w_word;
            end
            if (w_commit) begin
                r_left_sample  <= r_left_hold;
                r_right_sample <= w_word;
            end
            r_sample_valid <= w_commit;
            r_left_ok      <= w_left_ok_nxt;
            if (w_err_set) begin
                r_sync_error <= 1'b1;
            end else if (bus.clear_error) begin
                r_sync_error <= 1'b0;
            end
        end
    end

    assign bus.left_sample  = r_left_sample;
    assign bus.right_sample = r_right_sample;
    assign bus.sample_valid = r_sample_valid;
    assign bus.locked       = (r_state == c_ST_RECEIVE);
    assign bus.sync_error   = r_sync_error;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_stereo_receiver
// Brief    : Directed I2S streams into 16/32 and 24/24 receivers, scoreboarded.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_stereo_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16_n;
    logic rst24_n;
    logic ws;
    logic sd;
    logic clr;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q24[$];
    exp_t e16;
    exp_t e24;

    i2s_stereo_receiver_if #(.DATA_W(16)) bus16 ();
    i2s_stereo_receiver_if #(.DATA_W(24)) bus24 ();

    assign bus16.word_select = ws;
    assign bus16.sound_data  = sd;
    assign bus16.clear_error = clr;
    assign bus24.word_select = ws;
    assign bus24.sound_data  = sd;
    assign bus24.clear_error = clr;

    i2s_stereo_receiver #(.DATA_W(16), .SLOT_W(32), .LEFT_WS(1'b0)) dut16 (
        .serial_clk (clk),
        .reset      (rst16_n),
        .bus        (bus16)
    );

    i2s_stereo_receiver #(.DATA_W(24), .SLOT_W(24), .LEFT_WS(1'b0)) dut24 (
        .serial_clk (clk),
        .reset      (rst24_n),
        .bus        (bus24)
    );

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One slot of len cycles; word_select flips on the last (LSB) cycle.
    task automatic send_slot(input logic ch, input logic [23:0] data, input int dw,
                             input int len, input logic nxt);
        for (int k = 0; k < len; k++) begin
            ws = (k == len - 1) ? nxt : ch;
            sd = (k < dw) ? data[dw-1-k] : 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r, input int dw, input int len);
        send_slot(1'b0, l, dw, len, 1'b1);
        send_slot(1'b1, r, dw, len, 1'b0);
    endtask

    task automatic push16(input logic [23:0] l, input logic [23:0] r, input int due);
        q16.push_back('{l, r, due});
    endtask

    task automatic push24(input logic [23:0] l, input logic [23:0] r, input int due);
        q24.push_back('{l, r, due});
    endtask

    always @(negedge clk) begin
        if (bus16.sample_valid === 1'b1) begin
            chk("sb16_expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                chk("sb16_due", cyc, e16.due);
                chk("sb16_left", bus16.left_sample, e16.l);
                chk("sb16_right", bus16.right_sample, e16.r);
            end
        end else if (q16.size() != 0 && cyc > q16[0].due) begin
            chk("sb16_pulse", bus16.sample_valid, 64'd1);
            void'(q16.pop_front());
        end
        if (bus24.sample_valid === 1'b1) begin
            chk("sb24_expected", 64'(q24.size() != 0), 64'd1);
            if (q24.size() != 0) begin
                e24 = q24.pop_front();
                chk("sb24_due", cyc, e24.due);
                chk("sb24_left", bus24.left_sample, e24.l);
                chk("sb24_right", bus24.right_sample, e24.r);
            end
        end else if (q24.size() != 0 && cyc > q24[0].due) begin
            chk("sb24_pulse", bus24.sample_valid, 64'd1);
            void'(q24.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ws = 1'b0; sd = 1'b0; clr = 1'b0; rst16_n = 1'b0; rst24_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_left", bus16.left_sample, 64'd0);
        chk("rst_right", bus16.right_sample, 64'd0);
        chk("rst_valid", bus16.sample_valid, 64'd0);
        chk("rst_locked", bus16.locked, 64'd0);
        chk("rst_err", bus16.sync_error, 64'd0);
        rst16_n = 1'b1;

        // T1: lock, discard the orphan right slot, then one good pair
        send_slot(1'b0, 24'h0, 16, 32, 1'b1);
        chk("t1_locked", bus16.locked, 64'd1);
        send_slot(1'b1, 24'hFFFF, 16, 32, 1'b0);
        chk("t1_no_err", bus16.sync_error, 64'd0);
        push16(24'hA5C3, 24'h1234, cyc + 64);
        frame(24'hA5C3, 24'h1234, 16, 32);
        chk("t1_valid", bus16.sample_valid, 64'd1);
        chk("t1_left", bus16.left_sample, 64'hA5C3);
        chk("t1_right", bus16.right_sample, 64'h1234);

        // T2: 31-bit left slot
        send_slot(1'b0, 24'h1111, 16, 31, 1'b1);
        chk("t2_err", bus16.sync_error, 64'd1);
        chk("t2_locked", bus16.locked, 64'd1);
        send_slot(1'b1, 24'h2222, 16, 32, 1'b0);
        push16(24'h0F0F, 24'hF0F0, cyc + 64);
        frame(24'h0F0F, 24'hF0F0, 16, 32);
        chk("t2_left", bus16.left_sample, 64'h0F0F);
        push16(24'h1357, 24'h2468, cyc + 64);
        clr = 1'b1;
        send_slot(1'b0, 24'h1357, 16, 32, 1'b1);
        clr = 1'b0;
        chk("t2_cleared", bus16.sync_error, 64'd0);
        send_slot(1'b1, 24'h2468, 16, 32, 1'b0);

        // T3: word_select stuck for 40 cycles
        for (int k = 0; k < 31; k++) begin
            ws = 1'b0; sd = k[0];
            @(negedge clk);
        end
        chk("t3_locked_before", bus16.locked, 64'd1);
        chk("t3_err_before", bus16.sync_error, 64'd0);
        ws = 1'b0; @(negedge clk);
        chk("t3_err", bus16.sync_error, 64'd1);
        chk("t3_unlocked", bus16.locked, 64'd0);
        repeat (7) @(negedge clk);
        ws = 1'b1; @(negedge clk);
        chk("t3_relocked", bus16.locked, 64'd1);
        clr = 1'b1;
        send_slot(1'b1, 24'hBEEF, 16, 32, 1'b0);
        clr = 1'b0;
        chk("t3_cleared", bus16.sync_error, 64'd0);
        push16(24'h4321, 24'h8765, cyc + 64);
        frame(24'h4321, 24'h8765, 16, 32);

        // T6: clear_error coincides with a new short-slot error
        send_slot(1'b0, 24'h0, 16, 30, 1'b0);
        clr = 1'b1; ws = 1'b1; sd = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("t6_err_kept", bus16.sync_error, 64'd1);
        send_slot(1'b1, 24'h3333, 16, 32, 1'b0);

        // T5: reset in the middle of a right slot
        send_slot(1'b0, 24'hAAAA, 16, 32, 1'b1);
        send_slot(1'b1, 24'h5555, 16, 10, 1'b1);
        rst16_n = 1'b0; ws = 1'b0;
        #1;
        chk("t5_left", bus16.left_sample, 64'd0);
        chk("t5_right", bus16.right_sample, 64'd0);
        chk("t5_locked", bus16.locked, 64'd0);
        chk("t5_err", bus16.sync_error, 64'd0);
        repeat (2) @(negedge clk);
        rst16_n = 1'b1;
        send_slot(1'b0, 24'h0, 16, 32, 1'b1);
        send_slot(1'b1, 24'h7777, 16, 32, 1'b0);
        push16(24'hC0DE, 24'h0BAD, cyc + 64);
        frame(24'hC0DE, 24'h0BAD, 16, 32);
        chk("t5_left_after", bus16.left_sample, 64'hC0DE);

        // T4: 24-bit samples filling 24-bit slots
        rst16_n = 1'b0;
        rst24_n = 1'b1;
        send_slot(1'b0, 24'h0, 24, 24, 1'b1);
        chk("t4_locked", bus24.locked, 64'd1);
        send_slot(1'b1, 24'h123456, 24, 24, 1'b0);
        push24(24'h800001, 24'h7FFFFE, cyc + 48);
        frame(24'h800001, 24'h7FFFFE, 24, 24);
        chk("t4_left", bus24.left_sample, 64'h800001);
        chk("t4_right", bus24.right_sample, 64'h7FFFFE);

        repeat (4) @(negedge clk);
        chk("sb16_drained", q16.size(), 64'd0);
        chk("sb24_drained", q24.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
